note_track: RTL and testbench

- Gameplay-state stage directly upstream of the VGA display controller; owns the four falling-note slots the display draws.
- Advances notes once per frame and spawns new notes into four lanes from an LFSR.
- Judges PS/2 lane-key presses against a hit line and keeps score and combo.
- Display consumes slot_x/slot_y/slot_note/slot_active; keyboard side supplies decoded scan bytes.

---
 rtl/note_track.sv | 227 ++++++++++++++++++++++
 tb/tb_note_track.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_track.sv
// note_track: gameplay state upstream of the VGA display; spawns, advances and judges four falling-note slots.
// Optional build macro NOTE_TRACK_PAUSE_EN adds a space-bar pause toggle and the `paused` output.
module note_track #(
  parameter int unsigned LANE_X0        = 0,
  parameter int unsigned LANE_PITCH     = 80,
  parameter int unsigned SPEED          = 1,
  parameter int unsigned SPAWN_INTERVAL = 40,
  parameter int unsigned HIT_LINE       = 400,
  parameter int unsigned HIT_WINDOW     = 12,
  parameter int unsigned PERFECT_WINDOW = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  output logic [3:0]  slot_active,
  output logic [39:0] slot_x,
  output logic [39:0] slot_y,
  output logic [7:0]  slot_note,
  output logic [15:0] score,
  output logic [7:0]  combo,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic        spawn_drop
`ifdef NOTE_TRACK_PAUSE_EN
  ,
  output logic        paused
`endif
);

  localparam logic [9:0]  HitLine       = 10'(HIT_LINE);
  localparam logic [9:0]  MissAbove     = 10'(HIT_LINE + HIT_WINDOW);
  localparam logic [9:0]  HitWindow     = 10'(HIT_WINDOW);
  localparam logic [9:0]  PerfectWindow = 10'(PERFECT_WINDOW);
  localparam logic [15:0] SpawnLast     = 16'(SPAWN_INTERVAL - 1);

  typedef enum logic {KEY_MAKE, KEY_BREAK} keyState_t;

  keyState_t   keyState, keyStateNext;
  logic        frameTickQ;
  logic        tick;
  logic        pauseActive;
  logic [15:0] spawnCnt, spawnCntNext;
  logic [7:0]  lfsr, lfsrNext;

  logic [3:0]  activeNext;
  logic [39:0] xNext, yNext;
  logic [7:0]  noteNext;
  logic [15:0] scoreNext;
  logic [7:0]  comboNext;
  logic        hitNext, missNext, dropNext;
  logic [16:0] scoreSum;

  logic        laneKey;
  logic [1:0]  keyLane;
  logic        pressEn;
  logic        hitFound, hitPerfect;
  logic [1:0]  hitIdx;
  logic        freeFound;
  logic [1:0]  freeIdx;

  function automatic logic [9:0] lineDist(input logic [9:0] y);
    return (y >= HitLine) ? (y - HitLine) : (HitLine - y);
  endfunction

`ifdef NOTE_TRACK_PAUSE_EN
  logic pausedNext;
  assign pauseActive = paused;
`else
  assign pauseActive = 1'b0;
`endif

  assign tick    = frame_tick & ~frameTickQ & ~pauseActive;
  assign pressEn = key_valid && (keyState == KEY_MAKE) && laneKey && !pauseActive;

  always_comb begin
    laneKey = 1'b1;
    keyLane = 2'd0;
    case (key_code)
      8'h1C:   keyLane = 2'd0;
      8'h1B:   keyLane = 2'd1;
      8'h23:   keyLane = 2'd2;
      8'h2B:   keyLane = 2'd3;
      default: laneKey = 1'b0;
    endcase
  end

  // Both searches look at pre-tick slot state; lowest index wins.
  always_comb begin
    hitFound   = 1'b0;
    hitIdx     = 2'd0;
    hitPerfect = 1'b0;
    freeFound  = 1'b0;
    freeIdx    = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!hitFound && slot_active[i] && (slot_note[2*i +: 2] == keyLane) &&
          (lineDist(slot_y[10*i +: 10]) <= HitWindow)) begin
        hitFound   = 1'b1;
        hitIdx     = 2'(i);
        hitPerfect = lineDist(slot_y[10*i +: 10]) <= PerfectWindow;
      end
      if (!freeFound && !slot_active[i]) begin
        freeFound = 1'b1;
        freeIdx   = 2'(i);
      end
    end
  end

  always_comb begin
    keyStateNext = keyState;
    activeNext   = slot_active;
    xNext        = slot_x;
    yNext        = slot_y;
    noteNext     = slot_note;
    scoreNext    = score;
    comboNext    = combo;
    hitNext      = 1'b0;
    missNext     = 1'b0;
    dropNext     = spawn_drop;
    spawnCntNext = spawnCnt;
    lfsrNext     = lfsr;
    scoreSum     = {1'b0, score} + (hitPerfect ? 17'd2 : 17'd1);
`ifdef NOTE_TRACK_PAUSE_EN
    pausedNext   = paused;
`endif

    if (key_valid) begin
      if (keyState == KEY_BREAK)
        keyStateNext = KEY_MAKE;
      else if (key_code == 8'hF0)
        keyStateNext = KEY_BREAK;
`ifdef NOTE_TRACK_PAUSE_EN
      else if (key_code == 8'h29)
        pausedNext = ~paused;
`endif
    end

    if (pressEn) begin
      if (hitFound) begin
        activeNext[hitIdx] = 1'b0;
        hitNext            = 1'b1;
      end else begin
        missNext = 1'b1;
      end
    end

    // Key is judged before the tick: a slot just hit is already cleared in activeNext and stays put.
    if (tick) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (activeNext[i]) begin
          yNext[10*i +: 10] = slot_y[10*i +: 10] + 10'(SPEED);
          if (yNext[10*i +: 10] > MissAbove) begin
            activeNext[i] = 1'b0;
            missNext      = 1'b1;
          end
        end
      end

      if (spawnCnt == SpawnLast) begin
        spawnCntNext = '0;
        if (freeFound) begin
          activeNext[freeIdx]         = 1'b1;
          noteNext[2*freeIdx +: 2]    = lfsr[1:0];
          xNext[10*freeIdx +: 10]     = 10'(LANE_X0) + 10'(lfsr[1:0]) * 10'(LANE_PITCH);
          yNext[10*freeIdx +: 10]     = '0;
        end else begin
          dropNext = 1'b1;
        end
      end else begin
        spawnCntNext = spawnCnt + 16'd1;
      end

      lfsrNext = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    if (hitNext)
      scoreNext = scoreSum[16] ? '1 : scoreSum[15:0];

    if (missNext)
      comboNext = '0;
    else if (hitNext && (combo != 8'hFF))
      comboNext = combo + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      keyState    <= KEY_MAKE;
      frameTickQ  <= 1'b0;
      spawnCnt    <= '0;
      lfsr        <= 8'hA5;
      slot_active <= '0;
      slot_x      <= '0;
      slot_y      <= '0;
      slot_note   <= '0;
      score       <= '0;
      combo       <= '0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      spawn_drop  <= 1'b0;
    end else begin
      keyState    <= keyStateNext;
      frameTickQ  <= frame_tick;
      spawnCnt    <= spawnCntNext;
      lfsr        <= lfsrNext;
      slot_active <= activeNext;
      slot_x      <= xNext;
      slot_y      <= yNext;
      slot_note   <= noteNext;
      score       <= scoreNext;
      combo       <= comboNext;
      hit_pulse   <= hitNext;
      miss_pulse  <= missNext;
      spawn_drop  <= dropNext;
    end
  end

`ifdef NOTE_TRACK_PAUSE_EN
  always_ff @(posedge clk) begin
    if (reset)
      paused <= 1'b0;
    else
      paused <= pausedNext;
  end
`endif

endmodule

// File: tb/tb_note_track.sv
// Bench for note_track: directed literal checks followed by randomized frames and key presses,
// compared every cycle against a slot-level behavioural model.
module tb_note_track;

  localparam int X0       = 0;
  localparam int Pitch    = 80;
  localparam int Speed    = 1;
  localparam int Interval = 40;
  localparam int HitLine  = 400;
  localparam int HitWin   = 12;
  localparam int PerfWin  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        key_valid;
  logic [7:0]  key_code;
  logic [3:0]  slot_active;
  logic [39:0] slot_x;
  logic [39:0] slot_y;
  logic [7:0]  slot_note;
  logic [15:0] score;
  logic [7:0]  combo;
  logic        hit_pulse;
  logic        miss_pulse;
  logic        spawn_drop;

  note_track #(
    .LANE_X0(X0), .LANE_PITCH(Pitch), .SPEED(Speed), .SPAWN_INTERVAL(Interval),
    .HIT_LINE(HitLine), .HIT_WINDOW(HitWin), .PERFECT_WINDOW(PerfWin)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .key_valid(key_valid), .key_code(key_code),
    .slot_active(slot_active), .slot_x(slot_x), .slot_y(slot_y), .slot_note(slot_note),
    .score(score), .combo(combo), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .spawn_drop(spawn_drop)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  // Model state: one entry per slot, plus game counters.
  bit         mActive[4];
  int         mLane[4];
  int         mX[4];
  int         mY[4];
  int         mScore, mCombo, mCnt;
  bit         mHit, mMiss, mDrop, mBrk, mPrevFt;
  logic [7:0] mLfsr;
  logic [7:0] laneKeys[4] = '{8'h1C, 8'h1B, 8'h23, 8'h2B};
  logic [7:0] otherKeys[6] = '{8'hF0, 8'h29, 8'h00, 8'h1D, 8'h2C, 8'h5A};

  function automatic int laneOf(input logic [7:0] c);
    for (int i = 0; i < 4; i++)
      if (laneKeys[i] == c) return i;
    return -1;
  endfunction

  function automatic int absDist(input int y);
    return (y > HitLine) ? y - HitLine : HitLine - y;
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model, advanced on each rising clock edge from the sampled inputs.
  initial begin : modelProc
    bit tick;
    bit preActive[4];
    int lane, found, pts;
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < 4; i++) begin
          mActive[i] = 0; mLane[i] = 0; mX[i] = 0; mY[i] = 0;
        end
        mScore = 0; mCombo = 0; mCnt = 0;
        mHit = 0; mMiss = 0; mDrop = 0; mBrk = 0; mPrevFt = 0;
        mLfsr = 8'hA5;
        checking = 1'b1;
      end else begin
        tick = frame_tick && !mPrevFt;
        mPrevFt = frame_tick;
        mHit = 0; mMiss = 0; pts = 0;
        preActive = mActive;
        if (key_valid) begin
          if (mBrk) mBrk = 0;
          else if (key_code == 8'hF0) mBrk = 1;
          else begin
            lane = laneOf(key_code);
            if (lane >= 0) begin
              found = -1;
              for (int i = 0; i < 4; i++)
                if (found < 0 && mActive[i] && mLane[i] == lane && absDist(mY[i]) <= HitWin) found = i;
              if (found >= 0) begin
                mHit = 1;
                pts = (absDist(mY[found]) <= PerfWin) ? 2 : 1;
                mActive[found] = 0;
              end else mMiss = 1;
            end
          end
        end
        if (tick) begin
          for (int i = 0; i < 4; i++)
            if (mActive[i]) begin
              mY[i] += Speed;
              if (mY[i] > HitLine + HitWin) begin mActive[i] = 0; mMiss = 1; end
            end
          if (mCnt == Interval - 1) begin
            mCnt = 0;
            found = -1;
            for (int i = 0; i < 4; i++)
              if (found < 0 && !preActive[i]) found = i;
            if (found >= 0) begin
              mActive[found] = 1;
              mLane[found] = int'(mLfsr[1:0]);
              mX[found] = X0 + mLane[found] * Pitch;
              mY[found] = 0;
            end else mDrop = 1;
          end else mCnt++;
          mLfsr = {mLfsr[6:0], ^(mLfsr & 8'b1011_1000)};
        end
        mScore = (mScore + pts > 65535) ? 65535 : mScore + pts;
        if (mMiss) mCombo = 0;
        else if (mHit) mCombo = (mCombo < 255) ? mCombo + 1 : 255;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin : cmpProc
    logic [3:0] expA;
    forever begin
      @(negedge clk);
      if (checking) begin
        for (int i = 0; i < 4; i++) expA[i] = mActive[i];
        check("slot_active", 40'(slot_active), 40'(expA));
        for (int i = 0; i < 4; i++)
          if (mActive[i]) begin
            check($sformatf("slot_x[%0d]", i), 40'(slot_x[10*i +: 10]), 40'(mX[i]));
            check($sformatf("slot_y[%0d]", i), 40'(slot_y[10*i +: 10]), 40'(mY[i]));
            check($sformatf("slot_note[%0d]", i), 40'(slot_note[2*i +: 2]), 40'(mLane[i]));
          end
        check("score", 40'(score), 40'(mScore));
        check("combo", 40'(combo), 40'(mCombo));
        check("hit_pulse", 40'(hit_pulse), 40'(mHit));
        check("miss_pulse", 40'(miss_pulse), 40'(mMiss));
        check("spawn_drop", 40'(spawn_drop), 40'(mDrop));
      end
    end
  end

  task automatic drive(input bit ft, input bit kv, input logic [7:0] kc);
    @(negedge clk);
    frame_tick = ft;
    key_valid  = kv;
    key_code   = kc;
  endtask

  task automatic doTick();
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic press(input logic [7:0] kc);
    drive(1'b0, 1'b1, kc);
    drive(1'b0, 1'b0, 8'h00);
  endtask

  function automatic logic [7:0] pickKey(output bit want);
    for (int i = 0; i < 4; i++)
      if (mActive[i] && absDist(mY[i]) <= HitWin + 2) begin
        want = ($urandom_range(0, 2) == 0);
        return laneKeys[mLane[i]];
      end
    want = ($urandom_range(0, 39) == 0);
    if ($urandom_range(0, 1) == 0) return laneKeys[$urandom_range(0, 3)];
    return otherKeys[$urandom_range(0, 5)];
  endfunction

  initial begin : stimProc
    bit want;
    logic [7:0] kc;
    int hi, lo;
    reset = 1'b1; frame_tick = 1'b0; key_valid = 1'b0; key_code = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("reset slot_active", 40'(slot_active), 40'h0);
    check("reset score", 40'(score), 40'h0);
    check("reset combo", 40'(combo), 40'h0);
    check("reset spawn_drop", 40'(spawn_drop), 40'h0);
    reset = 1'b0;

    // First spawn on the 40th tick: LFSR after 39 shifts from A5 is CD, lane 1.
    repeat (39) doTick();
    check("pre-spawn slot_active", 40'(slot_active), 40'h0);
    doTick();
    check("first spawn slot_active", 40'(slot_active), 40'h1);
    check("first spawn lane", 40'(slot_note[1:0]), 40'd1);
    check("first spawn x", 40'(slot_x[9:0]), 40'd80);
    check("first spawn y", 40'(slot_y[9:0]), 40'd0);

    // Slots fill at ticks 40/80/120/160; tick 200 finds none free.
    repeat (159) doTick();
    check("spawn_drop before full", 40'(spawn_drop), 40'h0);
    doTick();
    check("spawn_drop set", 40'(spawn_drop), 40'h1);
    check("all slots active", 40'(slot_active), 40'hF);

    // Slot 0 reaches y=396 at tick 436: perfect hit in lane 1.
    repeat (236) doTick();
    check("slot0 y at 436", 40'(slot_y[9:0]), 40'd396);
    press(8'h1B);
    check("perfect hit_pulse", 40'(hit_pulse), 40'h1);
    check("perfect score", 40'(score), 40'd2);
    check("perfect combo", 40'(combo), 40'd1);
    check("hit slot freed", 40'(slot_active), 40'hE);

    // A break-prefixed lane byte is swallowed without judgement.
    drive(1'b0, 1'b1, 8'hF0);
    drive(1'b0, 1'b1, 8'h1C);
    drive(1'b0, 1'b0, 8'h00);
    check("break no hit", 40'(hit_pulse), 40'h0);
    check("break no miss", 40'(miss_pulse), 40'h0);
    check("break score kept", 40'(score), 40'd2);
    press(8'h1C);
    check("make judged", 40'(hit_pulse | miss_pulse), 40'h1);
    check("spawn_drop sticky", 40'(spawn_drop), 40'h1);

    // Randomized frames with a mid-run reset during a break sequence.
    for (int f = 0; f < 1400; f++) begin
      if (f == 700) begin
        drive(1'b0, 1'b1, 8'hF0);
        @(negedge clk);
        reset = 1'b1; frame_tick = 1'b0; key_valid = 1'b0;
        @(negedge clk);
        check("mid reset score", 40'(score), 40'h0);
        check("mid reset drop", 40'(spawn_drop), 40'h0);
        reset = 1'b0;
      end
      hi = $urandom_range(1, 3);
      lo = $urandom_range(1, 4);
      for (int c = 0; c < hi + lo; c++) begin
        kc = pickKey(want);
        drive(c < hi, want, kc);
      end
    end
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
